// File: rtl/crc_stream_pkg.sv
// Shared types and helpers for the CRC stream engine: FSM state encoding,
// the default CCITT polynomial, byte-lane selection and one-byte CRC step.
package crc_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        BYTE,
        DONE
    } state_t;

    localparam logic [15:0] DEFAULT_POLY16 = 16'h1021;

    // Widest buffer word the lane selector accepts (32 bytes).
    localparam int MAX_WORD_BITS = 256;

    // Pick byte `lane` out of a buffer word; with msb_first set, lane 0 is the
    // most significant byte of the word, otherwise it is bits [7:0].
    function automatic logic [7:0] lane_select(
        input logic [MAX_WORD_BITS-1:0] word,
        input int                       word_bytes,
        input int                       lane,
        input bit                       msb_first
    );
        int idx;
        idx = msb_first ? (word_bytes - 1 - lane) : lane;
        return word[8*idx +: 8];
    endfunction

    // Non-reflected CRC update for one byte, MSB first, no final XOR.
    // The CRC lives in the low crc_w bits of a 32-bit container.
    function automatic logic [31:0] crc_byte_step(
        input logic [31:0] crc_in,
        input logic [7:0]  data,
        input int          crc_w,
        input logic [31:0] poly
    );
        logic [31:0] c;
        logic [31:0] mask;
        mask = (crc_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << crc_w) - 32'd1);
        c    = crc_in ^ ({24'd0, data} << (crc_w - 8));
        for (int i = 0; i < 8; i++) begin
            if (c[crc_w-1]) begin
                c = ((c << 1) ^ poly) & mask;
            end else begin
                c = (c << 1) & mask;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_stream_engine_core.sv
// Generic registered CRC engine: init loads the seed, and each cycle with en
// high folds one byte into the running CRC.
module crc_byte_core
    import crc_stream_pkg::*;
#(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(DEFAULT_POLY16)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             init,
    input  logic [CRC_W-1:0] seed,
    input  logic             en,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc
);

    // Running CRC register: seed load has priority over a byte update.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            crc <= '0;
        end else if (init) begin
            crc <= seed;
        end else if (en) begin
            crc <= CRC_W'(crc_byte_step(32'(crc), data, CRC_W, 32'(POLY)));
        end
    end

endmodule

// File: rtl/crc_stream_engine.sv
// CRC sequencer: fetches a packed message word by word from a synchronous
// buffer, walks each word byte by byte into the CRC core and publishes the
// result with a one-cycle done pulse. Oversized lengths report err instead.
module crc_stream_engine
    import crc_stream_pkg::*;
#(
    parameter int               WORD_BYTES = 4,
    parameter int               ADDR_W     = 3,
    parameter int               LEN_W      = 8,
    parameter int               CRC_W      = 16,
    parameter logic [CRC_W-1:0] POLY       = CRC_W'(DEFAULT_POLY16),
    parameter bit               MSB_FIRST  = 1'b1
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CRC_W-1:0]        seed,
    input  logic [LEN_W-1:0]        length,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       addr,
    input  logic [8*WORD_BYTES-1:0] rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [CRC_W-1:0]        crc
);

    localparam int CAP        = WORD_BYTES << ADDR_W;
    localparam int LANE_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);
    localparam int WORD_W     = 8 * WORD_BYTES;

    state_t            state;
    logic [LEN_W-1:0]  byte_cnt;
    logic [LEN_W-1:0]  len_q;
    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] word_q;

    logic              core_init;
    logic              core_en;
    logic [7:0]        cur_byte;
    logic [CRC_W-1:0]  core_crc;
    logic [CRC_W-1:0]  crc_after_byte;
    logic              overflow;
    logic              last_byte;
    logic              lane_last;

    // Job-start decisions are made on the live length input, the rest on the
    // captured copy. The wide compare keeps CAP exact whatever LEN_W is.
    assign overflow  = (33'(length) > 33'(CAP));
    assign last_byte = (({1'b0, byte_cnt} + (LEN_W+1)'(1)) == {1'b0, len_q});
    assign lane_last = (lane == LANE_W'(WORD_BYTES - 1));

    // Buffer interface is a pure decode of the state and byte counter.
    assign rd_en = (state == FETCH);
    assign addr  = rd_en ? ADDR_W'(byte_cnt >> WORD_SHIFT) : '0;

    assign core_init = (state == IDLE) && start;
    assign core_en   = (state == BYTE);
    assign cur_byte  = lane_select(MAX_WORD_BITS'(word_q), WORD_BYTES, int'(lane), MSB_FIRST);

    // The result register samples the value the core is about to take, so
    // crc is already valid in the cycle done is high.
    assign crc_after_byte = CRC_W'(crc_byte_step(32'(core_crc), cur_byte, CRC_W, 32'(POLY)));

    crc_byte_core #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_core (
        .clk  (clk),
        .nrst (nrst),
        .init (core_init),
        .seed (seed),
        .en   (core_en),
        .data (cur_byte),
        .crc  (core_crc)
    );

    // Sequencer FSM with registered busy/done/err/crc; abort overrides every
    // transition out of a busy state, including a completion in the same cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            len_q    <= '0;
            lane     <= '0;
            word_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            crc      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if ((state != IDLE) && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            len_q    <= length;
                            byte_cnt <= '0;
                            lane     <= '0;
                            busy     <= 1'b1;
                            if (overflow) begin
                                state <= DONE;
                                done  <= 1'b1;
                                err   <= 1'b1;
                                crc   <= seed;
                            end else if (length == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                                crc   <= seed;
                            end else begin
                                state <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        state <= LATCH;
                    end
                    LATCH: begin
                        word_q <= rdata;
                        lane   <= '0;
                        state  <= BYTE;
                    end
                    BYTE: begin
                        byte_cnt <= byte_cnt + LEN_W'(1);
                        lane     <= lane + LANE_W'(1);
                        if (last_byte) begin
                            state <= DONE;
                            done  <= 1'b1;
                            crc   <= crc_after_byte;
                        end else if (lane_last) begin
                            state <= FETCH;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: a table of jobs with known CRCs and
// latencies, plus hand-written abort, restart, held-start and reset sequences.
// Three instances share stimulus: default, LSB-first lanes, and CRC-8.
module tb_crc_stream_engine;

    localparam int MAX_WAIT = 200;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic        abort;
    logic [15:0] seed;
    logic [7:0]  seed8;
    logic [7:0]  length;

    logic        rd_en_a, busy_a, done_a, err_a;
    logic [2:0]  addr_a;
    logic [31:0] rdata_a;
    logic [15:0] crc_a;

    logic        rd_en_l, busy_l, done_l, err_l;
    logic [2:0]  addr_l;
    logic [31:0] rdata_l;
    logic [15:0] crc_l;

    logic        rd_en_8, busy_8, done_8, err_8;
    logic [2:0]  addr_8;
    logic [31:0] rdata_8;
    logic [7:0]  crc_8;

    logic [31:0] mem   [8];
    logic [31:0] mem_l [8];

    int total = 0;
    int bad   = 0;

    int rd_cycles [$];
    int rd_addrs  [$];

    logic [15:0] crc_at, crc_l_at;
    logic [7:0]  crc_8_at;
    logic        err_at, err_l_at, done_l_at, done_8_at;

    typedef struct {
        logic [7:0]       len;
        logic [15:0]      seed;
        logic [0:7][31:0] words;
        logic [15:0]      exp_crc;
        logic             exp_err;
        int               exp_lat;
        int               exp_fetch;
    } vec_t;

    localparam int NUM_VECS = 10;
    vec_t vecs [NUM_VECS];

    always #5 clk = ~clk;

    crc_stream_engine dut (
        .clk (clk), .nrst (nrst), .start (start), .abort (abort),
        .seed (seed), .length (length), .rd_en (rd_en_a), .addr (addr_a),
        .rdata (rdata_a), .busy (busy_a), .done (done_a), .err (err_a), .crc (crc_a)
    );

    crc_stream_engine #(.MSB_FIRST (1'b0)) dut_l (
        .clk (clk), .nrst (nrst), .start (start), .abort (abort),
        .seed (seed), .length (length), .rd_en (rd_en_l), .addr (addr_l),
        .rdata (rdata_l), .busy (busy_l), .done (done_l), .err (err_l), .crc (crc_l)
    );

    crc_stream_engine #(.CRC_W (8), .POLY (8'h07)) dut_8 (
        .clk (clk), .nrst (nrst), .start (start), .abort (abort),
        .seed (seed8), .length (length), .rd_en (rd_en_8), .addr (addr_8),
        .rdata (rdata_8), .busy (busy_8), .done (done_8), .err (err_8), .crc (crc_8)
    );

    // Synchronous buffers: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en_a) rdata_a <= mem[addr_a];
        if (rd_en_8) rdata_8 <= mem[addr_8];
        if (rd_en_l) rdata_l <= mem_l[addr_l];
    end

    function automatic vec_t makeVec(
        input logic [7:0] len, input logic [15:0] sd,
        input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] fill,
        input logic [15:0] c, input logic e, input int lat, input int fet
    );
        vec_t v;
        v.len = len;
        v.seed = sd;
        v.words[0] = w0;
        v.words[1] = w1;
        for (int i = 2; i < 8; i++) v.words[i] = fill;
        v.exp_crc = c;
        v.exp_err = e;
        v.exp_lat = lat;
        v.exp_fetch = fet;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic loadWords(input logic [0:7][31:0] w);
        logic [31:0] x;
        for (int i = 0; i < 8; i++) begin
            x = w[i];
            mem[i]   = x;
            mem_l[i] = {x[7:0], x[15:8], x[23:16], x[31:24]};
        end
    endtask

    // Drives start for one cycle (cycle 0); returns at the cycle-1 negedge.
    task automatic applyStimulus(input logic [7:0] len, input logic [15:0] sd);
        length = len;
        seed   = sd;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts cycles from cycle 1 until done, logging reads; optionally pokes
    // start at two cycles of the job. lat stays -1 if done never arrives.
    task automatic waitDone(input int poke_a, input int poke_b, output int lat);
        int cyc;
        bit got;
        cyc = 1;
        got = 1'b0;
        lat = -1;
        rd_cycles.delete();
        rd_addrs.delete();
        while (!got && cyc <= MAX_WAIT) begin
            if (rd_en_a) begin
                rd_cycles.push_back(cyc);
                rd_addrs.push_back(int'(addr_a));
            end
            if (done_a) begin
                got       = 1'b1;
                lat       = cyc;
                crc_at    = crc_a;
                err_at    = err_a;
                crc_l_at  = crc_l;
                err_l_at  = err_l;
                done_l_at = done_l;
                crc_8_at  = crc_8;
                done_8_at = done_8;
            end else begin
                start = (cyc == poke_a) || (cyc == poke_b);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int  lat;
        int  cnt;
        bit  ok;
        int  exp_rd_cyc [3];
        int  exp_rd_addr[3];
        logic [0:7][31:0] check_words;

        vecs[0] = makeVec(8'd9,   16'hFFFF, 32'h31323334, 32'h35363738, 32'h39AAAAAA, 16'h29B1, 1'b0, 16, 3);
        vecs[1] = makeVec(8'd1,   16'h0000, 32'h01000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h1021, 1'b0, 4,  1);
        vecs[2] = makeVec(8'd2,   16'h0000, 32'h00015A5A, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h1021, 1'b0, 5,  1);
        vecs[3] = makeVec(8'd4,   16'h0000, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h1021, 1'b0, 7,  1);
        vecs[4] = makeVec(8'd5,   16'h0000, 32'h00000000, 32'h01FFFFFF, 32'hFFFFFFFF, 16'h1021, 1'b0, 10, 2);
        vecs[5] = makeVec(8'd0,   16'hABCD, 32'h11111111, 32'h22222222, 32'h33333333, 16'hABCD, 1'b0, 1,  0);
        vecs[6] = makeVec(8'd33,  16'h1234, 32'h11111111, 32'h22222222, 32'h33333333, 16'h1234, 1'b1, 1,  0);
        vecs[7] = makeVec(8'd255, 16'h0F0F, 32'h11111111, 32'h22222222, 32'h33333333, 16'h0F0F, 1'b1, 1,  0);
        vecs[8] = makeVec(8'd32,  16'h0000, 32'h00000000, 32'h00000000, 32'h00000000, 16'h0000, 1'b0, 49, 8);
        vecs[9] = makeVec(8'd1,   16'h0000, 32'h80FFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h9188, 1'b0, 4,  1);

        check_words = vecs[0].words;
        exp_rd_cyc  = '{1, 7, 13};
        exp_rd_addr = '{0, 1, 2};

        nrst   = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        seed   = '0;
        seed8  = '0;
        length = '0;
        loadWords(vecs[8].words);
        repeat (2) @(negedge clk);

        checkOutput("reset_busy",  32'(busy_a),  32'd0);
        checkOutput("reset_done",  32'(done_a),  32'd0);
        checkOutput("reset_err",   32'(err_a),   32'd0);
        checkOutput("reset_rd_en", 32'(rd_en_a), 32'd0);
        checkOutput("reset_addr",  32'(addr_a),  32'd0);
        checkOutput("reset_crc",   32'(crc_a),   32'd0);
        nrst = 1'b1;
        @(negedge clk);

        $display("[TB] table vectors");
        for (int i = 0; i < NUM_VECS; i++) begin
            loadWords(vecs[i].words);
            applyStimulus(vecs[i].len, vecs[i].seed);
            waitDone(0, 0, lat);
            checkOutput($sformatf("v%0d_lat", i),    32'(lat),             32'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d_crc", i),    32'(crc_at),          32'(vecs[i].exp_crc));
            checkOutput($sformatf("v%0d_err", i),    32'(err_at),          32'(vecs[i].exp_err));
            checkOutput($sformatf("v%0d_crc_l", i),  32'(crc_l_at),        32'(vecs[i].exp_crc));
            checkOutput($sformatf("v%0d_err_l", i),  32'(err_l_at),        32'(vecs[i].exp_err));
            checkOutput($sformatf("v%0d_done_l", i), 32'(done_l_at),       32'd1);
            checkOutput($sformatf("v%0d_fetch", i),  32'(rd_cycles.size()), 32'(vecs[i].exp_fetch));
            ok = 1'b1;
            for (int k = 0; k < rd_addrs.size(); k++) begin
                if (rd_addrs[k] != k) ok = 1'b0;
            end
            checkOutput($sformatf("v%0d_addr_seq", i), 32'(ok), 32'd1);
            @(negedge clk);
            checkOutput($sformatf("v%0d_done_fall", i), 32'(done_a), 32'd0);
            checkOutput($sformatf("v%0d_busy_fall", i), 32'(busy_a), 32'd0);
            checkOutput($sformatf("v%0d_busy_l", i),    32'(busy_l), 32'd0);
        end

        $display("[TB] abort in third BYTE cycle");
        loadWords(check_words);
        applyStimulus(8'd9, 16'hFFFF);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy",  32'(busy_a),  32'd0);
        checkOutput("abort_done",  32'(done_a),  32'd0);
        checkOutput("abort_rd_en", 32'(rd_en_a), 32'd0);
        checkOutput("abort_crc",   32'(crc_a),   32'(vecs[NUM_VECS-1].exp_crc));

        $display("[TB] restart with start pulses while busy");
        applyStimulus(8'd9, 16'hFFFF);
        waitDone(3, 8, lat);
        checkOutput("restart_lat", 32'(lat),    32'd16);
        checkOutput("restart_crc", 32'(crc_at), 32'h29B1);
        checkOutput("restart_nrd", 32'(rd_cycles.size()), 32'd3);
        if (rd_cycles.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("restart_rd_cyc%0d", k),  32'(rd_cycles[k]), 32'(exp_rd_cyc[k]));
                checkOutput($sformatf("restart_rd_addr%0d", k), 32'(rd_addrs[k]),  32'(exp_rd_addr[k]));
            end
        end
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy_a || done_a) cnt++;
        end
        checkOutput("restart_no_relaunch", 32'(cnt), 32'd0);

        $display("[TB] start held through DONE");
        loadWords(vecs[1].words);
        length = 8'd1;
        seed   = 16'h0000;
        start  = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("hold_done1", 32'(done_a), 32'd1);
        checkOutput("hold_crc1",  32'(crc_a),  32'h1021);
        @(negedge clk);
        checkOutput("hold_idle_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("hold_relaunch_busy",  32'(busy_a),  32'd1);
        checkOutput("hold_relaunch_rd_en", 32'(rd_en_a), 32'd1);
        waitDone(0, 0, lat);
        checkOutput("hold_lat2", 32'(lat),    32'd4);
        checkOutput("hold_crc2", 32'(crc_at), 32'h1021);
        @(negedge clk);

        $display("[TB] reset during BYTE");
        loadWords(check_words);
        applyStimulus(8'd9, 16'hFFFF);
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        checkOutput("rst_busy",  32'(busy_a),  32'd0);
        checkOutput("rst_done",  32'(done_a),  32'd0);
        checkOutput("rst_err",   32'(err_a),   32'd0);
        checkOutput("rst_rd_en", 32'(rd_en_a), 32'd0);
        checkOutput("rst_addr",  32'(addr_a),  32'd0);
        checkOutput("rst_crc",   32'(crc_a),   32'd0);
        checkOutput("rst_busy8", 32'(busy_8),  32'd0);
        checkOutput("rst_err8",  32'(err_8),   32'd0);
        checkOutput("rst_crc8",  32'(crc_8),   32'd0);
        applyStimulus(8'd9, 16'hFFFF);
        waitDone(0, 0, lat);
        checkOutput("post_rst_lat",   32'(lat),       32'd16);
        checkOutput("post_rst_crc",   32'(crc_at),    32'h29B1);
        checkOutput("post_rst_done8", 32'(done_8_at), 32'd1);
        checkOutput("post_rst_crc8",  32'(crc_8_at),  32'hF4);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised CRC sequencer that reads a packed message from a word-wide synchronous buffer, walks it byte by byte, and drives a generic CRC engine. It generalises the fixed 32-bit, 8-bit-seed, 32-byte-limit CRC-16 driver in the custom CRC IP. This version supports:
- configurable word width, buffer depth, CRC width and polynomial;
- full-range byte lengths and byte order;
- abort;
- overflow error reporting.

It sits between the AXI-accessible message RAM and the CRC result/status registers.

## Interface
- WORD_BYTES, 4: bytes per buffer word; power of 2, at least 1.
- ADDR_W, 3: buffer word-address width; capacity CAP = WORD_BYTES << ADDR_W bytes.
- LEN_W, 8: width of `length`.
- CRC_W, 16: CRC width, 8..32.
- POLY, 16'h1021: generator polynomial, normal form, CRC_W bits.
- MSB_FIRST, 1: 1 = byte 0 is rdata[8*WORD_BYTES-1 -: 8]; 0 = byte 0 is rdata[7:0].

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- nrst  in  1  reset; **synchronous, active-low**.
- start  in  1  sampled only in IDLE; a high sample launches a job.
- abort  in  1  sampled in any non-IDLE state.
- seed  in  CRC_W  initial CRC value, captured on start.
- length  in  LEN_W  message length in bytes, captured on start.
- rd_en  out  1  buffer read strobe.
- addr  out  ADDR_W  buffer word address.
- rdata  in  8*WORD_BYTES  buffer data, valid exactly 1 cycle after rd_en.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a job completes.
- err  out  1  high with done when length > CAP.
- crc  out  CRC_W  result register.

## Operation
States: IDLE, FETCH, LATCH, BYTE, DONE.
- **IDLE**
  - start=1: capture seed and length, load the CRC core with seed, clear byte_cnt.
  - If length > CAP (compare in LEN_W+1 bits), go to DONE with err_q=1.
  - Else if length==0, go to DONE.
  - Else go to FETCH.
- **FETCH**
  - rd_en=1, addr = byte_cnt / WORD_BYTES, truncated to ADDR_W. Go to LATCH.
- **LATCH**
  - Register rdata into word_q, set lane=0. Go to BYTE.
- **BYTE**
  - Feed word_q lane `lane` (ordered per MSB_FIRST) to the core; byte_cnt++, lane++.
  - If byte_cnt+1 == length, go to DONE.
  - Else if lane == WORD_BYTES-1, go to FETCH.
  - Else stay in BYTE.
- **DONE**
  - done=1, err=err_q.
  - crc <= core value, or seed when err_q=1. Go to IDLE.
- CRC algorithm: non-reflected, MSB of each byte first, no final XOR. Update: c = c ^ (byte << (CRC_W-8)), then 8 shift/conditional-XOR-POLY steps.
- Unused trailing lanes of the last word are never fed to the core.

Boundary conditions:
- **abort** in FETCH/LATCH/BYTE/DONE: next state is IDLE, no done pulse. crc keeps its previous completed value. abort beats completion in the same cycle.
- **start while busy**: ignored. A start held high through DONE relaunches from IDLE on the following cycle.
- **Reset**: nrst=0 at any time gives IDLE next edge. busy=0, done=0, err=0, rd_en=0, addr=0, crc=0, internal counters 0.
- **Full buffer**: length == CAP is legal. addr reaches 2^ADDR_W-1 and never wraps during a job.

## Timing
- Start sampled at cycle 0. The first rd_en is at cycle 1.
- Each word costs 2 overhead cycles (FETCH, LATCH) plus one cycle per consumed byte.
- done latency, start to done, for 1 ≤ length ≤ CAP: 2·ceil(length/WORD_BYTES) + length + 1 cycles.
- length==0 or overflow: done at cycle 1.
- crc and err are valid in the done cycle. crc then holds until the next completed job.
- busy rises at cycle 1 and falls the cycle after done.
- Registered outputs: busy, done, err, crc. rd_en and addr are state decodes with no combinational path from inputs.

## Structure
- Package `crc_stream_pkg`:
  - state enum (IDLE, FETCH, LATCH, BYTE, DONE);
  - DEFAULT_POLY16 = 16'h1021;
  - lane-select function (word, lane, MSB_FIRST) returning a byte.
- Sub-module `crc_byte_core #(CRC_W, POLY)`:
  - ports clk, nrst, init, seed, en, data[7:0], crc;
  - registered; one byte per en cycle; init loads seed.
- Top level: FSM, byte_cnt (LEN_W), lane counter (log2 WORD_BYTES, min 1 bit), word_q, err_q, result register.

## Test plan
- **Check string**, default parameters:
  - Stimulus: seed=16'hFFFF, length=9, words 32'h31323334, 32'h35363738, 32'h39xxxxxx.
  - Response: crc=16'h29B1, done at cycle 2·3+9+1=16, rd_en at cycles 1, 7, 13 with addr 0, 1, 2.
- **Single byte**:
  - Stimulus: seed=0, length=1, word0=32'h01000000.
  - Response: crc=16'h1021 at cycle 4. Repeat with MSB_FIRST=0 and word0=32'h00000001 for the same result.
- **Length 0 and overflow**:
  - length=0, seed=16'hABCD: done at cycle 1, crc=16'hABCD, err=0, no rd_en.
  - length=33 (CAP=32): done at cycle 1 with err=1.
- **Full buffer**:
  - length=32, all bytes 0, seed=0.
  - crc=0, addr sweeps 0..7 without wrap, done at cycle 49.
- **Abort and restart**:
  - abort in the 3rd BYTE cycle: IDLE next cycle, no done, crc unchanged.
  - An immediate restart with the check string still gives 16'h29B1.
  - start pulses while busy are ignored.
- **Reset mid-job**:
  - nrst=0 for 1 cycle during BYTE: all outputs 0 next cycle.
  - A following job with CRC_W=8, POLY=8'h07, seed=0, "123456789" gives crc=8'hF4.
